// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - control/status bundle between alu_seq_ctrl and its datapath.
interface alu_seq_ctrl_if #(
   parameter int CNT_W = 4
);
   logic             start;
   logic [1:0]       op;
   logic             q0;
   logic             q_1;
   logic             a_msb;
   logic             m_zero;
   logic [8:0]       c;
   logic             busy;
   logic             finish;
   logic             err;
   logic [CNT_W-1:0] cnt;

   modport master (
      output start, op, q0, q_1, a_msb, m_zero,
      input  c, busy, finish, err, cnt
   );

   modport slave (
      input  start, op, q0, q_1, a_msb, m_zero,
      output c, busy, finish, err, cnt
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequencer for an add/sub/Booth-mul/non-restoring-div datapath.
// Divide support is compiled in only when ALU_SEQ_DIV_EN is defined.
module alu_seq_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic           clk,
   input  logic           rst_b,
   alu_seq_ctrl_if.slave  bus
);
   localparam logic [1:0]       OP_ADD = 2'b00;
   localparam logic [1:0]       OP_SUB = 2'b01;
   localparam logic [1:0]       OP_MUL = 2'b10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_EXEC,
      S_MUL_TEST,
      S_MUL_SHIFT,
`ifdef ALU_SEQ_DIV_EN
      S_DIV_SHIFT,
      S_DIV_OP,
      S_DIV_SET,
      S_DIV_CORR,
`endif
      S_OUT_A,
      S_OUT_Q,
      S_DONE
   } state_t;

   state_t           r_state, w_next;
   logic [1:0]       r_op, w_op;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             r_err, w_err;
   logic [8:0]       w_c;
   logic             w_finish;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= S_IDLE;
         r_op    <= OP_ADD;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_op    <= w_op;
         r_cnt   <= w_cnt;
         r_err   <= w_err;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_op     = r_op;
      w_cnt    = r_cnt;
      w_err    = r_err;
      w_c      = '0;
      w_finish = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt = '0;
            if (bus.start) begin
               w_op  = bus.op;
               w_err = 1'b0;
               w_next = S_LOAD;
`ifndef ALU_SEQ_DIV_EN
               // Divide not built: reject immediately without touching the datapath
               if (bus.op == 2'b11) begin
                  w_err  = 1'b1;
                  w_next = S_DONE;
               end
`endif
            end
         end
         S_LOAD: begin
            w_c[0] = 1'b1;
            w_cnt  = '0;
            case (r_op)
               OP_ADD, OP_SUB: w_next = S_EXEC;
               OP_MUL:         w_next = S_MUL_TEST;
               default: begin
`ifdef ALU_SEQ_DIV_EN
                  if (bus.m_zero) begin
                     w_err  = 1'b1;
                     w_next = S_DONE;
                  end else begin
                     w_next = S_DIV_SHIFT;
                  end
`else
                  w_err  = 1'b1;
                  w_next = S_DONE;
`endif
               end
            endcase
         end
         S_EXEC: begin
            w_c[1] = (r_op == OP_ADD);
            w_c[2] = (r_op == OP_SUB);
            w_next = S_OUT_A;
         end
         S_MUL_TEST: begin
            w_c[2] = bus.q0 & ~bus.q_1;
            w_c[1] = ~bus.q0 & bus.q_1;
            w_next = S_MUL_SHIFT;
         end
         S_MUL_SHIFT: begin
            w_c[3] = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_next = S_OUT_A;
            end else begin
               w_cnt  = r_cnt + 1'b1;
               w_next = S_MUL_TEST;
            end
         end
`ifdef ALU_SEQ_DIV_EN
         S_DIV_SHIFT: begin
            w_c[4] = 1'b1;
            w_next = S_DIV_OP;
         end
         S_DIV_OP: begin
            w_c[2] = ~bus.a_msb;
            w_c[1] = bus.a_msb;
            w_next = S_DIV_SET;
         end
         S_DIV_SET: begin
            w_c[5] = ~bus.a_msb;
            if (r_cnt == CNT_LAST) begin
               w_next = S_DIV_CORR;
            end else begin
               w_cnt  = r_cnt + 1'b1;
               w_next = S_DIV_SHIFT;
            end
         end
         S_DIV_CORR: begin
            w_c[1] = bus.a_msb;
            w_next = S_OUT_A;
         end
`endif
         S_OUT_A: begin
            w_c[7] = 1'b1;
            w_next = r_op[1] ? S_OUT_Q : S_DONE;
         end
         S_OUT_Q: begin
            w_c[8] = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_finish = 1'b1;
            w_cnt    = '0;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

`ifndef ALU_SEQ_DIV_EN
   logic w_unused_div_flags;
   assign w_unused_div_flags = bus.a_msb ^ bus.m_zero;
`endif

   assign bus.c      = w_c;
   assign bus.busy   = (r_state != S_IDLE);
   assign bus.finish = w_finish;
   assign bus.err    = (r_state == S_DONE) & r_err;
   assign bus.cnt    = r_cnt;
endmodule
